// File: rtl/jtag_defines.sv
// jtag_defines: shared DMI widths, DTM op codes, IR codes, TAP state encoding and DTMCS fields
package jtag_defines;
    localparam int DMI_ADDR_W = 6;
    localparam int DMI_DATA_W = 32;
    localparam int DMI_OP_W   = 2;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'd0,
        DTM_READ  = 2'd1,
        DTM_WRITE = 2'd2
    } dtm_op_e;

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;
    localparam logic [4:0] IR_BYPASS = 5'h1f;

    typedef enum logic [3:0] {
        TAP_EX2_DR = 4'h0, TAP_EX1_DR = 4'h1, TAP_SH_DR  = 4'h2, TAP_PAU_DR = 4'h3,
        TAP_SEL_IR = 4'h4, TAP_UPD_DR = 4'h5, TAP_CAP_DR = 4'h6, TAP_SEL_DR = 4'h7,
        TAP_EX2_IR = 4'h8, TAP_EX1_IR = 4'h9, TAP_SH_IR  = 4'ha, TAP_PAU_IR = 4'hb,
        TAP_RTI    = 4'hc, TAP_UPD_IR = 4'hd, TAP_CAP_IR = 4'he, TAP_TLR    = 4'hf
    } tap_state_e;

    localparam logic [2:0] DTMCS_IDLE    = 3'd5;
    localparam logic [5:0] DTMCS_ABITS   = 6'd6;
    localparam logic [3:0] DTMCS_VERSION = 4'd1;
    localparam int DTMCS_DMIRESET     = 16;
    localparam int DTMCS_DMIHARDRESET = 17;
endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: IEEE 1149.1 16-state TAP controller advanced by clk-domain TCK rise events
module jtag_tap_fsm import jtag_defines::*; (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tck_rise,
    input  logic       tms,
    output tap_state_e state,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir
);
    tap_state_e next;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= TAP_TLR;
        else if (tck_rise) state <= next;

    always_comb begin
        next = state;
        case (state)
            TAP_TLR:    next = tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    next = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: next = tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: next = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  next = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: next = tms ? TAP_UPD_DR : TAP_PAU_DR;
            TAP_PAU_DR: next = tms ? TAP_EX2_DR : TAP_PAU_DR;
            TAP_EX2_DR: next = tms ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR: next = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR: next = tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: next = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  next = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: next = tms ? TAP_UPD_IR : TAP_PAU_IR;
            TAP_PAU_IR: next = tms ? TAP_EX2_IR : TAP_PAU_IR;
            TAP_EX2_IR: next = tms ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR: next = tms ? TAP_SEL_DR : TAP_RTI;
            default:    next = TAP_TLR;
        endcase
        capture_dr = tck_rise && state == TAP_CAP_DR;
        shift_dr   = tck_rise && state == TAP_SH_DR;
        update_dr  = tck_rise && state == TAP_UPD_DR;
        capture_ir = tck_rise && state == TAP_CAP_IR;
        shift_ir   = tck_rise && state == TAP_SH_IR;
        update_ir  = tck_rise && state == TAP_UPD_IR;
    end
endmodule

// File: rtl/jtag_dtm.sv
// jtag_dtm: RISC-V JTAG debug transport module bridging TAP DR scans to DMI requests
// JTAG_DTM_SYNC_EN selects 2-flop pin synchronizers instead of a single register stage.
module jtag_dtm import jtag_defines::*; #(
    parameter int          DMI_ADDR_BITS = DMI_ADDR_W,
    parameter int          DMI_DATA_BITS = DMI_DATA_W,
    parameter int          DMI_OP_BITS   = DMI_OP_W,
    parameter logic [31:0] IDCODE_VALUE  = 32'h1e200a6d,
    localparam int         L = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         jtag_tck,
    input  logic         jtag_tms,
    input  logic         jtag_tdi,
    output logic         jtag_tdo,
    output logic         dtm_req_valid,
    output logic [L-1:0] dtm_req_data,
    input  logic         dm_is_busy,
    input  logic [L-1:0] dm_resp_data
);
    localparam int LW = $clog2(L);

    logic [2:0] pins_s;
    logic tck_p, tck_rise, tck_fall;
    tap_state_e tap_state;
    logic cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir;
    logic [4:0] ir;
    logic [L-1:0] sr, sr_n, sh;
    logic [L-1:DMI_OP_BITS] last_resp;
    logic [LW-1:0] msb;
    logic [31:0] dtmcs;
    logic pending, sticky, seen, age, discard, busy_q;
    logic upd_dmi, req_ok, dm_fall, fast, dmireset, hardreset;
    logic resp_op_unused;

`ifdef JTAG_DTM_SYNC_EN
    logic [2:0] pins_m;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {pins_m, pins_s} <= '0;
        else {pins_m, pins_s} <= {jtag_tck, jtag_tms, jtag_tdi, pins_m};
`else
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pins_s <= '0;
        else pins_s <= {jtag_tck, jtag_tms, jtag_tdi};
`endif

    assign tck_rise = pins_s[2] & ~tck_p;
    assign tck_fall = ~pins_s[2] & tck_p;
    assign resp_op_unused = ^dm_resp_data[DMI_OP_BITS-1:0];

    jtag_tap_fsm u_tap (
        .clk(clk), .rst_n(rst_n), .tck_rise(tck_rise), .tms(pins_s[1]), .state(tap_state),
        .capture_dr(cap_dr), .shift_dr(sh_dr), .update_dr(upd_dr),
        .capture_ir(cap_ir), .shift_ir(sh_ir), .update_ir(upd_ir)
    );

    always_comb begin
        dtmcs = {14'b0, 3'b0, DTMCS_IDLE, sticky ? 2'd3 : 2'd0, DTMCS_ABITS, DTMCS_VERSION};
        msb = LW'(sh_ir ? 4 : (ir == IR_IDCODE || ir == IR_DTMCS) ? 31 : (ir == IR_DMI) ? L - 1 : 0);
        sh = sr >> 1;
        sh[msb] = pins_s[0];
        sr_n = cap_ir ? L'(5'b00001) :
               !cap_dr ? sh :
               (ir == IR_IDCODE) ? L'(IDCODE_VALUE) :
               (ir == IR_DTMCS) ? L'(dtmcs) :
               (ir == IR_DMI) ? {last_resp, {DMI_OP_BITS{sticky | pending}}} : '0;
        upd_dmi   = upd_dr && ir == IR_DMI;
        req_ok    = upd_dmi && !pending && !sticky;
        dmireset  = upd_dr && ir == IR_DTMCS && sr[DTMCS_DMIRESET];
        hardreset = upd_dr && ir == IR_DTMCS && sr[DTMCS_DMIHARDRESET];
        dm_fall   = busy_q && !dm_is_busy;
        fast      = pending && age && !seen && !dm_is_busy;
    end

    // a DM that never raises busy is treated as done two clocks after the strobe
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tck_p         <= 1'b0;
            busy_q        <= 1'b0;
            ir            <= IR_IDCODE;
            sr            <= '0;
            jtag_tdo      <= 1'b0;
            dtm_req_valid <= 1'b0;
            dtm_req_data  <= '0;
            pending       <= 1'b0;
            sticky        <= 1'b0;
            seen          <= 1'b0;
            age           <= 1'b0;
            discard       <= 1'b0;
            last_resp     <= '0;
        end else begin
            tck_p         <= pins_s[2];
            busy_q        <= dm_is_busy;
            ir            <= (tap_state == TAP_TLR) ? IR_IDCODE : upd_ir ? sr[4:0] : ir;
            if (cap_ir || cap_dr || sh_ir || sh_dr) sr <= sr_n;
            if (tck_fall) jtag_tdo <= (tap_state == TAP_SH_DR || tap_state == TAP_SH_IR) && sr[0];
            dtm_req_valid <= req_ok;
            if (req_ok) dtm_req_data <= sr;
            pending       <= req_ok || (pending && !(hardreset || dm_fall || fast));
            sticky        <= (upd_dmi && !req_ok) || (cap_dr && ir == IR_DMI && pending) ||
                             (sticky && !(dmireset || hardreset));
            seen          <= !req_ok && (seen || dm_is_busy);
            age           <= !req_ok && pending;
            discard       <= hardreset ? pending && (seen || dm_is_busy) : discard && !dm_fall;
            if (dm_fall && !discard) last_resp <= dm_resp_data[L-1:DMI_OP_BITS];
        end
endmodule

// File: tb/tb_jtag_dtm.sv
// tb_jtag_dtm: directed JTAG scans against jtag_dtm with hand-computed expectations
module tb_jtag_dtm;
    import jtag_defines::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jtag_tck = 1'b0;
    logic        jtag_tms = 1'b1;
    logic        jtag_tdi = 1'b0;
    logic        jtag_tdo;
    logic        dtm_req_valid;
    logic [39:0] dtm_req_data;
    logic        dm_is_busy = 1'b0;
    logic [39:0] dm_resp_data = '0;

    int checks = 0;
    int failures = 0;
    int req_cnt = 0;
    logic [39:0] req_last = '0;
    logic [39:0] d;
    logic [4:0] irv;
    logic b;

    jtag_dtm dut (
        .clk(clk), .rst_n(rst_n), .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
        .jtag_tdo(jtag_tdo), .dtm_req_valid(dtm_req_valid), .dtm_req_data(dtm_req_data),
        .dm_is_busy(dm_is_busy), .dm_resp_data(dm_resp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (dtm_req_valid) begin
            req_cnt  <= req_cnt + 1;
            req_last <= dtm_req_data;
        end

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tck_cycle(input logic ms, input logic di, output logic o);
        jtag_tms = ms;
        jtag_tdi = di;
        #40;
        o = jtag_tdo;
        jtag_tck = 1'b1;
        #40;
        jtag_tck = 1'b0;
    endtask

    task automatic shift_ir(input logic [4:0] v, output logic [4:0] o);
        logic t;
        o = '0;
        tck_cycle(1, 0, t); tck_cycle(1, 0, t); tck_cycle(0, 0, t); tck_cycle(0, 0, t);
        for (int i = 0; i < 5; i++) begin
            tck_cycle(i == 4, v[i], t);
            o[i] = t;
        end
        tck_cycle(1, 0, t); tck_cycle(0, 0, t);
    endtask

    task automatic shift_dr(input logic [39:0] v, input int n, output logic [39:0] o);
        logic t;
        o = '0;
        tck_cycle(1, 0, t); tck_cycle(0, 0, t); tck_cycle(0, 0, t);
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, v[i], t);
            o[i] = t;
        end
        tck_cycle(1, 0, t); tck_cycle(0, 0, t);
    endtask

    initial begin
        #23;
        check("rst_tdo", 40'(jtag_tdo), 40'd0);
        check("rst_valid", 40'(dtm_req_valid), 40'd0);
        check("rst_data", dtm_req_data, 40'd0);
        check("rst_tap", 40'(dut.tap_state), 40'(TAP_TLR));
        rst_n = 1'b1;
        #20;
        tck_cycle(0, 0, b);

        shift_dr(40'd0, 32, d);
        check("idcode", d, 40'h001e200a6d);
        shift_ir(5'h10, irv);
        check("ir_capture", 40'(irv), 40'd1);
        shift_dr(40'd0, 32, d);
        check("dtmcs", d, 40'h0000005061);

        shift_ir(5'h11, irv);
        shift_dr(40'h4000000006, 40, d);
        check("dmi_cap_idle", d, 40'd0);
        #100;
        check("req_cnt_1", 40'(req_cnt), 40'd1);
        check("req_data_1", req_last, 40'h4000000006);
        dm_is_busy = 1'b1;
        #50;
        dm_resp_data = 40'h4000000000;
        dm_is_busy = 1'b0;
        #50;
        shift_dr(40'h0800000000, 40, d);
        check("dmi_resp", d, 40'h4000000000);
        #100;
        check("req_cnt_2", 40'(req_cnt), 40'd2);

        dm_is_busy = 1'b1;
        #50;
        shift_dr(40'h4000000016, 40, d);
        check("dmi_held_first", d, 40'h4000000000);
        #100;
        check("req_cnt_3", 40'(req_cnt), 40'd3);
        shift_dr(40'h40000000fe, 40, d);
        check("dmi_cap_pending", d, 40'h4000000003);
        shift_dr(40'd0, 40, d);
        check("dmi_cap_sticky", d, 40'h4000000003);
        check("req_cnt_dropped", 40'(req_cnt), 40'd3);
        check("req_data_kept", req_last, 40'h4000000016);

        shift_ir(5'h10, irv);
        shift_dr(40'h0000010000, 32, d);
        check("dtmcs_sticky", d, 40'h0000005c61);
        shift_dr(40'd0, 32, d);
        check("dtmcs_cleared", d, 40'h0000005061);

        dm_resp_data = 40'h1234567890;
        dm_is_busy = 1'b0;
        #50;
        shift_ir(5'h11, irv);
        shift_dr(40'h0800000000, 40, d);
        check("dmi_after_release", d, 40'h1234567890);
        #100;
        check("req_cnt_4", 40'(req_cnt), 40'd4);

        shift_ir(5'h10, irv);
        tck_cycle(1, 0, b); tck_cycle(0, 0, b); tck_cycle(0, 0, b);
        for (int i = 0; i < 3; i++) tck_cycle(0, 1, b);
        for (int i = 0; i < 5; i++) tck_cycle(1, 0, b);
        #40;
        check("tlr_tap", 40'(dut.tap_state), 40'(TAP_TLR));
        tck_cycle(0, 0, b);
        shift_dr(40'd0, 32, d);
        check("idcode_after_tlr", d, 40'h001e200a6d);
        check("req_cnt_tlr", 40'(req_cnt), 40'd4);

        tck_cycle(1, 0, b); tck_cycle(0, 0, b); tck_cycle(0, 0, b);
        #40;
        check("tdo_pre_reset", 40'(jtag_tdo), 40'd1);
        check("req_data_pre_reset", dtm_req_data, 40'h0800000000);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_tdo", 40'(jtag_tdo), 40'd0);
        check("arst_valid", 40'(dtm_req_valid), 40'd0);
        check("arst_data", dtm_req_data, 40'd0);
        check("arst_tap", 40'(dut.tap_state), 40'(TAP_TLR));
        #20;
        rst_n = 1'b1;
        #60;
        check("post_rst_tap", 40'(dut.tap_state), 40'(TAP_TLR));
        check("req_cnt_final", 40'(req_cnt), 40'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
